keypad_scan_ctrl: RTL and testbench

- Sequencer for the 4x4 calculator keypad; sits between the keypad pins and the calculator FSM.
- Drives one row low at a time and samples the columns through a synchronizer.
- Debounces press and release, then emits a one-cycle key_valid pulse with an 8-bit key code.
- Encoding matches the calculator datapath: digits have bit7=0, operators have upper nibble 4'b1111.

---
 rtl/keypad_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with column synchronizer,
// press/release debounce and calculator key encoding.
// Optional build macro KEYPAD_AUTOREPEAT_EN: while a key stays held, re-pulse
// key_valid every REPEAT_FRAMES sample points (Clear and = never repeat).
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV      = 4,
  parameter int unsigned DEB_CNT       = 3,
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_LAST = 4'(DEB_CNT);

  if (SCAN_DIV < 2 || SCAN_DIV > 256 || DEB_CNT < 1 || DEB_CNT > 15 ||
      REPEAT_FRAMES < 1) begin : g_param_check
    $error("keypad_scan_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state;
  logic [3:0]    col_m, col_s;
  logic [DW-1:0] div_cnt;
  logic [3:0]    stable_cnt, rel_cnt;
  logic [1:0]    key_row, key_col;
  logic [1:0]    row_idx, col_idx;
  logic [3:0]    col_low, row_rot;
  logic          sample, single_low, same_key;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES);
  logic [RW-1:0] rep_cnt;
  logic          no_repeat;
  assign no_repeat = (key_code == 8'hE1) || (key_code == 8'hE0);
`endif

  function automatic logic [7:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:    key_map = 8'h01;
      4'd1:    key_map = 8'h02;
      4'd2:    key_map = 8'h03;
      4'd3:    key_map = 8'hF0;
      4'd4:    key_map = 8'h04;
      4'd5:    key_map = 8'h05;
      4'd6:    key_map = 8'h06;
      4'd7:    key_map = 8'hF1;
      4'd8:    key_map = 8'h07;
      4'd9:    key_map = 8'h08;
      4'd10:   key_map = 8'h09;
      4'd11:   key_map = 8'hF2;
      4'd12:   key_map = 8'hE1;
      4'd13:   key_map = 8'h00;
      4'd14:   key_map = 8'hE0;
      default: key_map = 8'hF3;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_m <= '1;
      col_s <= '1;
    end else begin
      col_m <= col_n;
      col_s <= col_m;
    end
  end

  // Row-period divider; its last count is the sample point
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Decode the synchronized columns and the currently driven row
  always_comb begin
    sample     = (div_cnt == DIV_LAST);
    col_low    = ~col_s;
    single_low = (col_low != 4'h0) && ((col_low & (col_low - 4'd1)) == 4'h0);
    same_key   = (col_low == (4'b0001 << key_col));
    row_rot    = {row_n[2:0], row_n[3]};
    col_idx    = 2'd0;
    if (col_low[1]) col_idx = 2'd1;
    if (col_low[2]) col_idx = 2'd2;
    if (col_low[3]) col_idx = 2'd3;
    row_idx = 2'd0;
    if (!row_n[1]) row_idx = 2'd1;
    if (!row_n[2]) row_idx = 2'd2;
    if (!row_n[3]) row_idx = 2'd3;
  end

  // Scan / debounce / held sequencer with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCAN;
      row_n      <= 4'b1110;
      key_code   <= 8'hFF;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      multi_err  <= 1'b0;
      stable_cnt <= '0;
      rel_cnt    <= '0;
      key_row    <= '0;
      key_col    <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      if (sample) begin
        case (state)
          SCAN: begin
            if (col_s == 4'hF) begin
              row_n <= row_rot;
            end else if (single_low) begin
              key_row <= row_idx;
              key_col <= col_idx;
              if (DEB_CNT == 1) begin
                key_code  <= key_map({row_idx, col_idx});
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rel_cnt   <= '0;
                state     <= HELD;
              end else begin
                stable_cnt <= 4'd1;
                state      <= DEBOUNCE;
              end
            end else begin
              multi_err <= 1'b1;
              row_n     <= row_rot;
            end
          end
          DEBOUNCE: begin
            if (same_key) begin
              if (stable_cnt + 4'd1 == DEB_LAST) begin
                key_code   <= key_map({key_row, key_col});
                key_valid  <= 1'b1;
                key_held   <= 1'b1;
                stable_cnt <= '0;
                rel_cnt    <= '0;
                state      <= HELD;
              end else begin
                stable_cnt <= stable_cnt + 4'd1;
              end
            end else begin
              stable_cnt <= '0;
              row_n      <= row_rot;
              state      <= SCAN;
            end
          end
          HELD: begin
            if (col_s == 4'hF) begin
              if (rel_cnt + 4'd1 == DEB_LAST) begin
                key_held <= 1'b0;
                rel_cnt  <= '0;
                row_n    <= row_rot;
                state    <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + 4'd1;
              end
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
            end else begin
              rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              if (same_key && !no_repeat) begin
                if (rep_cnt + RW'(1) == REP_LAST) begin
                  key_valid <= 1'b1;
                  rep_cnt   <= '0;
                end else begin
                  rep_cnt <= rep_cnt + RW'(1);
                end
              end
`endif
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench with a resistive-matrix keypad model
// (column low when its key is pressed on the driven row).
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;
  int both_cnt = 0;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] code;
    logic [3:0] row;
  } vec_t;

  vec_t vec [16];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_DIV(4),
    .DEB_CNT(3),
    .REPEAT_FRAMES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_n(col_n),
    .row_n(row_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .multi_err(multi_err)
  );

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_n[r] == 1'b0 && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk)
    if (key_valid === 1'b1 && multi_err === 1'b1) both_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk(name, key_valid, 1'b1);
  endtask

  task automatic wait_row_enter(input logic [3:0] pat);
    logic [3:0] prev;
    int n;
    n = 0;
    do begin
      prev = row_n;
      tick();
      n++;
    end while (!(row_n == pat && prev != pat) && n < 64);
    chk("row_enter", row_n, pat);
  endtask

  task automatic release_wait(input string name, output int n, output int pulses);
    keys = '0;
    n = 0;
    pulses = 0;
    while (key_held !== 1'b0 && n < 40) begin
      tick();
      n++;
      if (key_valid === 1'b1) pulses++;
    end
    chk(name, key_held, 1'b0);
  endtask

  // Called on the negedge where rst rises: row0 is driven for 4 clk, then rotates
  task automatic check_rotation();
    int n;
    n = 0;
    while (row_n == 4'b1110 && n < 16) begin
      tick();
      n++;
    end
    chk("rot_period", n, 4);
    chk("rot_row1", row_n, 4'b1101);
    repeat (4) tick();
    chk("rot_row2", row_n, 4'b1011);
  endtask

  initial begin
    int n;
    int pulses;
    int rep_exp;

    vec[0]  = '{4'd0,  8'h01, 4'b1110};
    vec[1]  = '{4'd1,  8'h02, 4'b1110};
    vec[2]  = '{4'd2,  8'h03, 4'b1110};
    vec[3]  = '{4'd3,  8'hF0, 4'b1110};
    vec[4]  = '{4'd4,  8'h04, 4'b1101};
    vec[5]  = '{4'd5,  8'h05, 4'b1101};
    vec[6]  = '{4'd6,  8'h06, 4'b1101};
    vec[7]  = '{4'd7,  8'hF1, 4'b1101};
    vec[8]  = '{4'd8,  8'h07, 4'b1011};
    vec[9]  = '{4'd9,  8'h08, 4'b1011};
    vec[10] = '{4'd10, 8'h09, 4'b1011};
    vec[11] = '{4'd11, 8'hF2, 4'b1011};
    vec[12] = '{4'd12, 8'hE1, 4'b0111};
    vec[13] = '{4'd13, 8'h00, 4'b0111};
    vec[14] = '{4'd14, 8'hE0, 4'b0111};
    vec[15] = '{4'd15, 8'hF3, 4'b0111};

`ifdef KEYPAD_AUTOREPEAT_EN
    rep_exp = 4;
`else
    rep_exp = 0;
`endif

    // Reset state
    keys = '0;
    rst  = 1'b0;
    repeat (3) tick();
    chk("rst_row_n", row_n, 4'b1110);
    chk("rst_key_code", key_code, 8'hFF);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_held", key_held, 1'b0);
    chk("rst_multi_err", multi_err, 1'b0);
    rst = 1'b1;
    check_rotation();

    // "6": latency from row1 being driven, then 12 clk release debounce
    wait_row_enter(4'b1101);
    keys[6] = 1'b1;
    wait_valid("six_valid", n);
    chk_range("six_latency", n, 9, 15);
    chk("six_code", key_code, 8'h06);
    chk("six_held", key_held, 1'b1);
    chk("six_row_frozen", row_n, 4'b1101);
    release_wait("six_release", n, pulses);
    chk("six_release_clk", n, 12);
    chk("six_extra_valid", pulses, 0);
    chk("six_row_after", row_n, 4'b1011);

    // Every key once: code, frozen row, single pulse, release debounce
    for (int unsigned i = 0; i < 16; i++) begin
      keys = '0;
      keys[vec[i].idx] = 1'b1;
      wait_valid("tbl_valid", n);
      chk($sformatf("tbl_code_%0d", i), key_code, vec[i].code);
      chk($sformatf("tbl_held_%0d", i), key_held, 1'b1);
      chk($sformatf("tbl_row_%0d", i), row_n, vec[i].row);
      release_wait("tbl_release", n, pulses);
      chk($sformatf("tbl_release_clk_%0d", i), n, 12);
      chk($sformatf("tbl_single_pulse_%0d", i), pulses, 0);
    end

    // "+" glitch lasting one sample: debounce aborts, scan moves to row1
    wait_row_enter(4'b1110);
    keys[3] = 1'b1;
    pulses = 0;
    repeat (4) begin
      tick();
      if (key_valid === 1'b1) pulses++;
    end
    chk("glitch_row_frozen", row_n, 4'b1110);
    keys = '0;
    repeat (4) begin
      tick();
      if (key_valid === 1'b1) pulses++;
    end
    chk("glitch_row_next", row_n, 4'b1101);
    repeat (8) begin
      tick();
      if (key_valid === 1'b1) pulses++;
    end
    chk("glitch_no_valid", pulses, 0);
    chk("glitch_code_kept", key_code, 8'hF3);
    chk("glitch_held", key_held, 1'b0);

    // Row3 with col0 and col2 low together
    wait_row_enter(4'b0111);
    keys[12] = 1'b1;
    keys[14] = 1'b1;
    repeat (4) tick();
    chk("multi_pulse", multi_err, 1'b1);
    chk("multi_no_valid_now", key_valid, 1'b0);
    chk("multi_row_adv", row_n, 4'b1110);
    keys = '0;
    pulses = 0;
    n = 0;
    repeat (16) begin
      tick();
      if (key_valid === 1'b1) pulses++;
      if (multi_err === 1'b1) n++;
    end
    chk("multi_no_valid", pulses, 0);
    chk("multi_single_pulse", n, 0);

    // "=" then reset mid-HELD
    keys[14] = 1'b1;
    wait_valid("eq_valid", n);
    chk("eq_code", key_code, 8'hE0);
    tick();
    tick();
    chk("eq_held", key_held, 1'b1);
    rst  = 1'b0;
    keys = '0;
    #1;
    chk("eqrst_held", key_held, 1'b0);
    chk("eqrst_code", key_code, 8'hFF);
    chk("eqrst_row", row_n, 4'b1110);
    chk("eqrst_valid", key_valid, 1'b0);
    tick();
    rst = 1'b1;
    check_rotation();

    // Long hold of "9": repeats only with auto-repeat built in
    keys[10] = 1'b1;
    wait_valid("nine_valid", n);
    chk("nine_code", key_code, 8'h09);
    pulses = 0;
    repeat (144) begin
      tick();
      if (key_valid === 1'b1) pulses++;
    end
    chk("nine_repeats", pulses, rep_exp);
    chk("nine_code_kept", key_code, 8'h09);
    chk("nine_held", key_held, 1'b1);
    release_wait("nine_release", n, pulses);

    // Long hold of Clear: never repeats
    keys[12] = 1'b1;
    wait_valid("clr_valid", n);
    chk("clr_code", key_code, 8'hE1);
    pulses = 0;
    repeat (144) begin
      tick();
      if (key_valid === 1'b1) pulses++;
    end
    chk("clr_repeats", pulses, 0);
    release_wait("clr_release", n, pulses);

    chk("valid_err_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
